// File: rtl/sda_kernel_axi_lite_bridge.sv
// AXI4-Lite slave for the kernel control port: each AXI read or write becomes one
// transaction on the simple regReq/regAck register bus, with timeout on unmapped addresses.
module sda_kernel_axi_lite_bridge #(
  parameter int unsigned RegAddrWidth  = 8,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [RegAddrWidth-1:0] s_axi_awaddr,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [RegAddrWidth-1:0] s_axi_araddr,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  input  logic [31:0]             regRData
);

  typedef enum logic [1:0] {StIdle, StReq, StWResp, StRResp} stateT;

  localparam logic [RegAddrWidth-1:0] AddrMask    = ~RegAddrWidth'(3);
  localparam logic [7:0]              TimeoutLast = 8'(TimeoutCycles - 1);

  stateT                   state, stateD;
  logic                    awFull, wFull, arFull;
  logic                    awFullD, wFullD, arFullD;
  logic [RegAddrWidth-1:0] awAddrBuf, arAddrBuf;
  logic [31:0]             wDataBuf;
  logic [3:0]              wStrbBuf;
  logic                    wrPend, rdPend;
  logic                    lastWasWrite, curIsWrite;
  logic [7:0]              toCnt;
  logic                    awAccept, wAccept, arAccept;
  logic                    pickWrite, pickRead, strbFull, reqTimeout;

  always_comb begin
    awAccept   = s_axi_awvalid & s_axi_awready;
    wAccept    = s_axi_wvalid & s_axi_wready;
    arAccept   = s_axi_arvalid & s_axi_arready;
    // On a tie, serve whichever type did not go last.
    pickWrite  = wrPend & (~rdPend | ~lastWasWrite);
    pickRead   = rdPend & ~pickWrite;
    strbFull   = (wStrbBuf == 4'hF);
    reqTimeout = ~regAck & (toCnt == TimeoutLast);
    stateD     = state;
    awFullD    = awFull | awAccept;
    wFullD     = wFull | wAccept;
    arFullD    = arFull | arAccept;
    unique case (state)
      StIdle: begin
        if (pickWrite) begin
          stateD = strbFull ? StReq : StWResp;
        end else if (pickRead) begin
          stateD = StReq;
        end
      end
      StReq: begin
        if (regAck || reqTimeout) begin
          stateD = curIsWrite ? StWResp : StRResp;
        end
      end
      StWResp: begin
        if (s_axi_bready) begin
          stateD  = StIdle;
          awFullD = 1'b0;
          wFullD  = 1'b0;
        end
      end
      StRResp: begin
        if (s_axi_rready) begin
          stateD  = StIdle;
          arFullD = 1'b0;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      awFull        <= 1'b0;
      wFull         <= 1'b0;
      arFull        <= 1'b0;
      awAddrBuf     <= '0;
      arAddrBuf     <= '0;
      wDataBuf      <= '0;
      wStrbBuf      <= '0;
      wrPend        <= 1'b0;
      rdPend        <= 1'b0;
      lastWasWrite  <= 1'b0;
      curIsWrite    <= 1'b0;
      toCnt         <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      regReq        <= 1'b0;
      regWriteEn    <= 1'b0;
      regAddr       <= '0;
      regWData      <= '0;
    end else begin
      state  <= stateD;
      awFull <= awFullD;
      wFull  <= wFullD;
      arFull <= arFullD;
      if (awAccept) awAddrBuf <= s_axi_awaddr;
      if (arAccept) arAddrBuf <= s_axi_araddr;
      if (wAccept) begin
        wDataBuf <= s_axi_wdata;
        wStrbBuf <= s_axi_wstrb;
      end
      s_axi_awready <= (stateD == StIdle) & ~awFullD;
      s_axi_wready  <= (stateD == StIdle) & ~wFullD;
      s_axi_arready <= (stateD == StIdle) & ~arFullD;
      // Pending flags are a registered view of the buffers, held low outside idle.
      wrPend <= (state == StIdle) & (stateD == StIdle) & awFull & wFull;
      rdPend <= (state == StIdle) & (stateD == StIdle) & arFull;
      unique case (state)
        StIdle: begin
          if (pickWrite) begin
            curIsWrite <= 1'b1;
            regWriteEn <= 1'b1;
            regAddr    <= awAddrBuf & AddrMask;
            regWData   <= wDataBuf;
            toCnt      <= '0;
            if (strbFull) begin
              regReq <= 1'b1;
            end else begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= 2'b10;
            end
          end else if (pickRead) begin
            curIsWrite <= 1'b0;
            regWriteEn <= 1'b0;
            regAddr    <= arAddrBuf & AddrMask;
            toCnt      <= '0;
            regReq     <= 1'b1;
          end
        end
        StReq: begin
          if (regAck || reqTimeout) begin
            regReq <= 1'b0;
            if (curIsWrite) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= regAck ? 2'b00 : 2'b10;
            end else begin
              s_axi_rvalid <= 1'b1;
              s_axi_rresp  <= regAck ? 2'b00 : 2'b10;
              s_axi_rdata  <= regAck ? regRData : 32'h0;
            end
          end else begin
            toCnt <= toCnt + 8'd1;
          end
        end
        StWResp: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            lastWasWrite <= 1'b1;
          end
        end
        StRResp: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            lastWasWrite <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_kernel_axi_lite_bridge.sv
// Directed bench for sda_kernel_axi_lite_bridge: table of single transactions plus
// hand-written arbitration and mid-transaction reset sequences.
module tb_sda_kernel_axi_lite_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        regReq, regAck, regWriteEn;
  logic [7:0]  regAddr;
  logic [31:0] regWData, regRData;

  always #5 clk = ~clk;

  sda_kernel_axi_lite_bridge #(.RegAddrWidth(8), .TimeoutCycles(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn), .regAddr(regAddr),
    .regWData(regWData), .regRData(regRData)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-block model: acks in the second cycle of regReq unless muted.
  logic        ackQ;
  logic        slaveMute = 1'b0;
  logic [31:0] slaveData = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ackQ <= 1'b0;
    else        ackQ <= regReq && !ackQ && !slaveMute;
  end
  assign regAck   = ackQ;
  assign regRData = ackQ ? slaveData : 32'h0;

  int          reqTotal = 0;
  logic        mWe;
  logic [7:0]  mAddr;
  logic [31:0] mWData;
  always @(negedge clk) begin
    if (regReq) begin
      reqTotal <= reqTotal + 1;
      mWe      <= regWriteEn;
      mAddr    <= regAddr;
      mWData   <= regWData;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within bound", name);
  endtask

  task automatic sendAw(input logic [7:0] a, output int hs);
    bit ok = 0;
    hs = -1;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin
        hs = cyc;
        ok = 1;
        @(posedge clk);
        #1;
      end
    end
    s_axi_awvalid = 1'b0;
    if (!ok) boundExpired("aw_handshake");
  endtask

  task automatic sendW(input logic [31:0] d, input logic [3:0] s, output int hs);
    bit ok = 0;
    hs = -1;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_wready) begin
        hs = cyc;
        ok = 1;
        @(posedge clk);
        #1;
      end
    end
    s_axi_wvalid = 1'b0;
    if (!ok) boundExpired("w_handshake");
  endtask

  task automatic sendAr(input logic [7:0] a, output int hs);
    bit ok = 0;
    hs = -1;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        hs = cyc;
        ok = 1;
        @(posedge clk);
        #1;
      end
    end
    s_axi_arvalid = 1'b0;
    if (!ok) boundExpired("ar_handshake");
  endtask

  task automatic getB(output logic [1:0] resp, output int vc);
    bit ok = 0;
    resp = 2'bxx;
    vc   = -1;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        vc   = cyc;
        ok   = 1;
        @(posedge clk);
        #1;
      end
    end
    s_axi_bready = 1'b0;
    if (!ok) boundExpired("b_response");
  endtask

  task automatic getR(output logic [1:0] resp, output logic [31:0] data, output int vc);
    bit ok = 0;
    resp = 2'bxx;
    data = 'x;
    vc   = -1;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin
        resp = s_axi_rresp;
        data = s_axi_rdata;
        vc   = cyc;
        ok   = 1;
        @(posedge clk);
        #1;
      end
    end
    s_axi_rready = 1'b0;
    if (!ok) boundExpired("r_response");
  endtask

  typedef struct {
    bit          isWrite;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wLead;    // >0: W leads AW by this many cycles; <0: AW leads W
    bit          mute;
    logic [31:0] ackData;
    logic [1:0]  expResp;
    logic [31:0] expRdata;
    int          expReq;
    logic [7:0]  expAddr;
    int          expLat;   // -1: not checked
  } vecT;

  vecT         vecs[8];
  vecT         v;
  int          awHs, wHs, arHs, acc, bCyc, rCyc, r0;
  logic [1:0]  bResp, rResp;
  logic [31:0] rData;

  task automatic tieRound(input bit expWriteFirst, input logic [7:0] wa, input logic [31:0] wd,
                          input logic [7:0] ra, input logic [31:0] rd, input string tag);
    int a1, a2, a3, bc, rc;
    logic [1:0] br, rr;
    logic [31:0] rdat;
    slaveData = rd;
    fork
      sendAw(wa, a1);
      sendW(wd, 4'hF, a2);
      sendAr(ra, a3);
    join
    check({tag, "_same_accept"}, {a1 == a3, a2 == a3}, 2'b11);
    fork
      getB(br, bc);
      getR(rr, rdat, rc);
    join
    check({tag, "_write_first"}, bc < rc, expWriteFirst);
    check({tag, "_bresp"}, br, 2'b00);
    check({tag, "_rresp"}, rr, 2'b00);
    check({tag, "_rdata"}, rdat, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 8'h00, 32'h1,        4'hF, 0,  0, 32'h0,        2'b00, 32'h0,        2,  8'h00, 5};
    vecs[1] = '{1, 8'h00, 32'hAA,       4'hF, 3,  0, 32'h0,        2'b00, 32'h0,        2,  8'h00, 5};
    vecs[2] = '{0, 8'h00, 32'h0,        4'h0, 0,  0, 32'h6,        2'b00, 32'h6,        2,  8'h00, 5};
    vecs[3] = '{0, 8'h40, 32'h0,        4'h0, 0,  1, 32'hFFFFFFFF, 2'b10, 32'h0,        16, 8'h40, -1};
    vecs[4] = '{0, 8'h04, 32'h0,        4'h0, 0,  0, 32'h12345678, 2'b00, 32'h12345678, 2,  8'h04, 5};
    vecs[5] = '{1, 8'h08, 32'hDEAD,     4'h3, 0,  0, 32'h0,        2'b10, 32'h0,        0,  8'h00, -1};
    vecs[6] = '{0, 8'h07, 32'h0,        4'h0, 0,  0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D, 2,  8'h04, 5};
    vecs[7] = '{1, 8'h0E, 32'h5A5A5A5A, 4'hF, -2, 0, 32'h0,        2'b00, 32'h0,        2,  8'h0C, 5};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_bresp, s_axi_rvalid,
           s_axi_rdata, s_axi_rresp, regReq, regWriteEn, regAddr, regWData}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_low_before_first_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(posedge clk);
    #1;
    check("ready_high_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      slaveMute = v.mute;
      slaveData = v.ackData;
      r0 = reqTotal;
      if (v.isWrite) begin
        fork
          begin
            if (v.wLead < 0) begin repeat (-v.wLead) @(posedge clk); #1; end
            sendW(v.wdata, v.strb, wHs);
          end
          begin
            if (v.wLead > 0) begin repeat (v.wLead) @(posedge clk); #1; end
            sendAw(v.addr, awHs);
          end
        join
        acc = (awHs > wHs) ? awHs : wHs;
        getB(bResp, bCyc);
        check($sformatf("v%0d_bresp", i), bResp, v.expResp);
      end else begin
        sendAr(v.addr, arHs);
        acc = arHs;
        getR(rResp, rData, bCyc);
        check($sformatf("v%0d_rresp", i), rResp, v.expResp);
        check($sformatf("v%0d_rdata", i), rData, v.expRdata);
      end
      check($sformatf("v%0d_req_cycles", i), reqTotal - r0, v.expReq);
      if (v.expReq > 0) begin
        check($sformatf("v%0d_req_we", i), mWe, v.isWrite);
        check($sformatf("v%0d_req_addr", i), mAddr, v.expAddr);
        if (v.isWrite) check($sformatf("v%0d_req_wdata", i), mWData, v.wdata);
      end
      if (v.expLat >= 0) check($sformatf("v%0d_latency", i), bCyc - acc, v.expLat);
    end
    slaveMute = 1'b0;

    // Last served was a write; a lone read flips it so the next tie goes to the write.
    slaveData = 32'h11;
    sendAr(8'h10, arHs);
    getR(rResp, rData, rCyc);
    check("solo_read_rdata", rData, 32'h11);
    tieRound(1'b1, 8'h14, 32'hA1, 8'h18, 32'hB1, "tie1");
    // After a lone write the next tie must go to the read.
    fork
      sendAw(8'h1C, awHs);
      sendW(32'hC3, 4'hF, wHs);
    join
    getB(bResp, bCyc);
    check("solo_write_bresp", bResp, 2'b00);
    tieRound(1'b0, 8'h24, 32'hA2, 8'h28, 32'hB2, "tie2");

    // Reset in the middle of a read request that will never be acked.
    slaveMute = 1'b1;
    sendAr(8'h20, arHs);
    for (int i = 0; i < 20 && !regReq; i++) @(negedge clk);
    check("mid_req_seen", {regReq, regAddr}, {1'b1, 8'h20});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs_zero",
          {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_bresp, s_axi_rvalid,
           s_axi_rdata, s_axi_rresp, regReq, regWriteEn, regAddr, regWData}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slaveMute = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ready_after_release", {s_axi_awready, s_axi_wready, s_axi_arready},
          3'b111);
    check("midreset_no_response", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    slaveData = 32'h77;
    r0 = reqTotal;
    sendAr(8'h10, arHs);
    getR(rResp, rData, rCyc);
    check("post_reset_rresp", rResp, 2'b00);
    check("post_reset_rdata", rData, 32'h77);
    check("post_reset_req_cycles", reqTotal - r0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
